// File: rtl/alu_share_arb.sv
// Two-requester arbiter sharing one 4-bit add/sub unit; one operation in flight at a time,
// result held in a per-requester response buffer until the response handshake completes.

module adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       cin,
    output logic [3:0] o_result,
    output logic       o_carry,
    output logic       o_overflow,
    output logic       zero
);
    logic [3:0] b_eff;
    logic [4:0] sum;

    // Subtraction negates b first, so a-0 yields carry=0.
    always_comb begin
        b_eff      = (cin ? ~i_b : i_b) + {3'b000, cin};
        sum        = {1'b0, i_a} + {1'b0, b_eff};
        o_result   = sum[3:0];
        o_carry    = sum[4];
        o_overflow = (i_a[3] == b_eff[3]) && (sum[3] != i_a[3]);
        zero       = (sum[3:0] == 4'd0);
    end
endmodule

module alu_share_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_sub,
    output logic       resp0_valid,
    input  logic       resp0_ready,
    output logic [3:0] resp0_result,
    output logic [2:0] resp0_flags,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_sub,
    output logic       resp1_valid,
    input  logic       resp1_ready,
    output logic [3:0] resp1_result,
    output logic [2:0] resp1_flags,
    output logic       busy,
    output logic       grant_id
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e     state;
    logic       last_grant;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_sub;
    logic       arb_grant;
    logic       resp_taken;
    logic [3:0] add_result;
    logic       add_carry;
    logic       add_overflow;
    logic       add_zero;

    adder u_adder (
        .i_a        (op_a),
        .i_b        (op_b),
        .cin        (op_sub),
        .o_result   (add_result),
        .o_carry    (add_carry),
        .o_overflow (add_overflow),
        .zero       (add_zero)
    );

    always_comb begin
        if (req0_valid && req1_valid) begin
            arb_grant = RR_EN ? ~last_grant : 1'b0;
        end else begin
            arb_grant = req1_valid;
        end
        req0_ready = (state == StIdle) && req0_valid && !arb_grant;
        req1_ready = (state == StIdle) && req1_valid && arb_grant;
        resp_taken = grant_id ? resp1_ready : resp0_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            last_grant   <= 1'b1;
            op_a         <= 4'd0;
            op_b         <= 4'd0;
            op_sub       <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            resp0_valid  <= 1'b0;
            resp0_result <= 4'd0;
            resp0_flags  <= 3'd0;
            resp1_valid  <= 1'b0;
            resp1_result <= 4'd0;
            resp1_flags  <= 3'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (req0_valid || req1_valid) begin
                        op_a     <= arb_grant ? req1_a : req0_a;
                        op_b     <= arb_grant ? req1_b : req0_b;
                        op_sub   <= arb_grant ? req1_sub : req0_sub;
                        grant_id <= arb_grant;
                        busy     <= 1'b1;
                        state    <= StExec;
                    end
                end
                StExec: begin
                    if (grant_id) begin
                        resp1_valid  <= 1'b1;
                        resp1_result <= add_result;
                        resp1_flags  <= {add_carry, add_overflow, add_zero};
                    end else begin
                        resp0_valid  <= 1'b1;
                        resp0_result <= add_result;
                        resp0_flags  <= {add_carry, add_overflow, add_zero};
                    end
                    state <= StResp;
                end
                StResp: begin
                    if (resp_taken) begin
                        last_grant   <= grant_id;
                        busy         <= 1'b0;
                        resp0_valid  <= 1'b0;
                        resp0_result <= 4'd0;
                        resp0_flags  <= 3'd0;
                        resp1_valid  <= 1'b0;
                        resp1_result <= 4'd0;
                        resp1_flags  <= 3'd0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_alu_share_arb;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       q_valid  [2][2];
    logic [3:0] q_a      [2][2];
    logic [3:0] q_b      [2][2];
    logic       q_sub    [2][2];
    logic       s_ready  [2][2];
    logic       q_ready  [2][2];
    logic       s_valid  [2][2];
    logic [3:0] s_result [2][2];
    logic [2:0] s_flags  [2][2];
    logic       d_busy   [2];
    logic       d_grant  [2];

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            alu_share_arb #(.RR_EN(k == 0)) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .req0_valid   (q_valid[k][0]),
                .req0_ready   (q_ready[k][0]),
                .req0_a       (q_a[k][0]),
                .req0_b       (q_b[k][0]),
                .req0_sub     (q_sub[k][0]),
                .resp0_valid  (s_valid[k][0]),
                .resp0_ready  (s_ready[k][0]),
                .resp0_result (s_result[k][0]),
                .resp0_flags  (s_flags[k][0]),
                .req1_valid   (q_valid[k][1]),
                .req1_ready   (q_ready[k][1]),
                .req1_a       (q_a[k][1]),
                .req1_b       (q_b[k][1]),
                .req1_sub     (q_sub[k][1]),
                .resp1_valid  (s_valid[k][1]),
                .resp1_ready  (s_ready[k][1]),
                .resp1_result (s_result[k][1]),
                .resp1_flags  (s_flags[k][1]),
                .busy         (d_busy[k]),
                .grant_id     (d_grant[k])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {carry, overflow, zero, result} from plain integer arithmetic.
    function automatic logic [6:0] calc(input int a, input int b, input bit sub);
        int bp, s, sa, sb, ss;
        logic [2:0] f;
        bp = sub ? (16 - b) % 16 : b;
        s  = a + bp;
        sa = (a >= 8) ? a - 16 : a;
        sb = (bp >= 8) ? bp - 16 : bp;
        ss = sa + sb;
        f  = {s >= 16, (ss > 7) || (ss < -8), (s % 16) == 0};
        return {f, 4'(s % 16)};
    endfunction

    function automatic int arb(input bit rr, input int last, input bit v0, input bit v1);
        if (v0 && v1) return rr ? 1 - last : 0;
        return v1 ? 1 : 0;
    endfunction

    // Model: one op in flight; resp phase begins the cycle after the exec cycle.
    bit         m_busy  [2];
    bit         m_resp  [2];
    int         m_owner [2];
    int         m_last  [2];
    logic [6:0] m_out   [2];
    bit         acc_seen[2][2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_resp[k] = 0; m_owner[k] = 0; m_last[k] = 1; m_out[k] = '0;
            for (int n = 0; n < 2; n++) begin
                q_valid[k][n] = 0; q_a[k][n] = 0; q_b[k][n] = 0; q_sub[k][n] = 0;
                s_ready[k][n] = 0; acc_seen[k][n] = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int  g;
        bit  rv;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("rst_busy[%0d]", k), d_busy[k], 0);
                chk($sformatf("rst_grant[%0d]", k), d_grant[k], 0);
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("rst_resp_valid[%0d][%0d]", k, n), s_valid[k][n], 0);
                    chk($sformatf("rst_result[%0d][%0d]", k, n), s_result[k][n], 0);
                    chk($sformatf("rst_flags[%0d][%0d]", k, n), s_flags[k][n], 0);
                end
                m_busy[k] = 0; m_resp[k] = 0; m_last[k] = 1;
            end else begin
                g = arb(k == 0, m_last[k], q_valid[k][0], q_valid[k][1]);
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("req_ready[%0d][%0d]", k, n), q_ready[k][n],
                        !m_busy[k] && q_valid[k][n] && g == n);
                    rv = m_busy[k] && m_resp[k] && m_owner[k] == n;
                    chk($sformatf("resp_valid[%0d][%0d]", k, n), s_valid[k][n], rv);
                    chk($sformatf("resp_result[%0d][%0d]", k, n), s_result[k][n],
                        rv ? m_out[k][3:0] : 4'd0);
                    chk($sformatf("resp_flags[%0d][%0d]", k, n), s_flags[k][n],
                        rv ? m_out[k][6:4] : 3'd0);
                    if (q_valid[k][n] && q_ready[k][n]) acc_seen[k][n] = 1;
                end
                chk($sformatf("busy[%0d]", k), d_busy[k], m_busy[k]);
                if (m_busy[k]) chk($sformatf("grant_id[%0d]", k), d_grant[k], m_owner[k][0]);
                if (!m_busy[k] && (q_valid[k][0] || q_valid[k][1])) begin
                    m_busy[k]  = 1;
                    m_resp[k]  = 0;
                    m_owner[k] = g;
                    m_out[k]   = calc(q_a[k][g], q_b[k][g], q_sub[k][g]);
                end else if (m_busy[k] && !m_resp[k]) begin
                    m_resp[k] = 1;
                end else if (m_busy[k] && s_ready[k][m_owner[k]]) begin
                    m_busy[k] = 0;
                    m_last[k] = m_owner[k];
                end
            end
        end
    end

    task automatic direct_op(input int n, input logic [3:0] a, input logic [3:0] b,
                             input logic sub, input logic [3:0] er, input logic [2:0] ef);
        @(posedge clk); #1;
        q_valid[0][n] = 1; q_a[0][n] = a; q_b[0][n] = b; q_sub[0][n] = sub;
        s_ready[0][n] = 1;
        @(negedge clk);
        chk($sformatf("dir_ready_T[%0d]", n), q_ready[0][n], 1);
        @(posedge clk); #1;
        q_valid[0][n] = 0;
        @(negedge clk);
        chk($sformatf("dir_valid_T1[%0d]", n), s_valid[0][n], 0);
        chk($sformatf("dir_busy_T1[%0d]", n), d_busy[0], 1);
        @(negedge clk);
        chk($sformatf("dir_valid_T2[%0d]", n), s_valid[0][n], 1);
        chk($sformatf("dir_result_T2[%0d]", n), s_result[0][n], er);
        chk($sformatf("dir_flags_T2[%0d]", n), s_flags[0][n], ef);
    endtask

    task automatic idle_all(input int cycles);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 2; n++) begin
                q_valid[k][n] = 0; s_ready[k][n] = 1;
            end
        repeat (cycles) @(posedge clk);
    endtask

    int gl_rr[$];
    int tl_rr[$];
    int gl_fp[$];

    initial begin
        chk("model_7p1", calc(7, 1, 0), {3'b010, 4'd8});
        chk("model_15p1", calc(15, 1, 0), {3'b101, 4'd0});
        chk("model_3m5", calc(3, 5, 1), {3'b000, 4'b1110});
        chk("model_5m0", calc(5, 0, 1), {3'b000, 4'd5});

        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        chk("reset_busy", d_busy[0], 0);
        chk("reset_resp0", s_valid[0][0], 0);
        #2 rst_n = 1;

        direct_op(0, 4'd7, 4'd1, 1'b0, 4'd8, 3'b010);
        direct_op(0, 4'd5, 4'd0, 1'b1, 4'd5, 3'b000);
        direct_op(1, 4'd15, 4'd1, 1'b0, 4'd0, 3'b101);
        direct_op(1, 4'd3, 4'd5, 1'b1, 4'b1110, 3'b000);

        // Both requesters continuously valid on both instances.
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 2; n++) begin
                q_valid[k][n] = 1; s_ready[k][n] = 1;
                q_a[k][n] = 4'($urandom_range(0, 15)); q_b[k][n] = 4'($urandom_range(0, 15));
            end
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (q_valid[0][n] && q_ready[0][n]) begin gl_rr.push_back(n); tl_rr.push_back(cyc); end
                if (q_valid[1][n] && q_ready[1][n]) gl_fp.push_back(n);
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                for (int n = 0; n < 2; n++) begin
                    q_a[k][n] = 4'($urandom_range(0, 15)); q_sub[k][n] = 1'($urandom_range(0, 1));
                end
        end
        chk("rr_accept_count", gl_rr.size() >= 4, 1);
        chk("fp_accept_count", gl_fp.size() >= 3, 1);
        for (int i = 0; i < 4 && i < gl_rr.size(); i++) begin
            chk($sformatf("rr_grant_%0d", i), gl_rr[i], i % 2);
            if (i > 0) chk($sformatf("rr_spacing_%0d", i), tl_rr[i] - tl_rr[i-1], 3);
        end
        for (int i = 0; i < 3 && i < gl_fp.size(); i++)
            chk($sformatf("fp_grant_%0d", i), gl_fp[i], 0);
        idle_all(5);

        // Response stall on requester 0 while requester 1 waits.
        @(posedge clk); #1;
        q_valid[0][0] = 1; q_a[0][0] = 4'd2; q_b[0][0] = 4'd3; q_sub[0][0] = 0;
        s_ready[0][0] = 0;
        @(negedge clk);
        chk("stall_accept0", q_ready[0][0], 1);
        @(posedge clk); #1;
        q_valid[0][0] = 0;
        q_valid[0][1] = 1; q_a[0][1] = 4'd9; q_b[0][1] = 4'd9; q_sub[0][1] = 1;
        @(negedge clk);
        chk("stall_exec_ready1", q_ready[0][1], 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid0", s_valid[0][0], 1);
            chk("stall_result0", s_result[0][0], 5);
            chk("stall_busy", d_busy[0], 1);
            chk("stall_ready1", q_ready[0][1], 0);
        end
        @(posedge clk); #1;
        s_ready[0][0] = 1;
        @(negedge clk);
        chk("release_valid0", s_valid[0][0], 1);
        @(negedge clk);
        chk("release_accept1", q_ready[0][1], 1);
        chk("release_cleared0", s_valid[0][0], 0);
        idle_all(5);

        // Reset pulse while an op is in EXEC.
        @(posedge clk); #1;
        q_valid[0][0] = 1; q_a[0][0] = 4'd1; q_b[0][0] = 4'd1; q_sub[0][0] = 0;
        @(negedge clk);
        chk("rst_op_accept", q_ready[0][0], 1);
        @(posedge clk); #1;
        q_valid[0][0] = 0;
        #2 rst_n = 0;
        #1;
        chk("async_busy", d_busy[0], 0);
        chk("async_valid0", s_valid[0][0], 0);
        chk("async_valid1", s_valid[0][1], 0);
        @(posedge clk); #2;
        rst_n = 1;
        @(negedge clk);
        chk("discarded_no_resp", s_valid[0][0], 0);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 2; n++) q_valid[k][n] = 1;
        @(negedge clk);
        chk("post_rst_tie0", q_ready[0][0], 1);
        chk("post_rst_tie1", q_ready[0][1], 0);
        idle_all(5);

        // Randomized traffic with random response back-pressure.
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 2; n++) acc_seen[k][n] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                for (int n = 0; n < 2; n++) begin
                    if (acc_seen[k][n]) begin
                        acc_seen[k][n] = 0;
                        q_valid[k][n]  = 0;
                    end
                    if (!q_valid[k][n] && $urandom_range(0, 2) != 0) begin
                        q_valid[k][n] = 1;
                        q_a[k][n]     = 4'($urandom_range(0, 15));
                        q_b[k][n]     = 4'($urandom_range(0, 15));
                        q_sub[k][n]   = 1'($urandom_range(0, 1));
                    end
                    s_ready[k][n] = ($urandom_range(0, 3) != 0);
                end
        end
        idle_all(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
